// File: rtl/register_file_pkg.sv
// Shared widths, dump-sequencer state encoding and helpers for the MIPS register file.
package register_file_pkg;

  localparam int unsigned NB_DATA = 32;
  localparam int unsigned NB_REG  = 5;
  localparam int unsigned N_REGS  = 2 ** NB_REG;

  typedef enum logic [1:0] {
    DumpIdle = 2'b00,
    DumpSend = 2'b01,
    DumpDone = 2'b10
  } dump_state_e;

  function automatic logic is_last_index(input logic [NB_REG-1:0] idx);
    return idx == NB_REG'(N_REGS - 1);
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Dump sequencer: walks register indices 0..N_REGS-1 under a valid/ready handshake and tells
// the storage owner when and which word to load into the dump output register.
module regfile_dump_ctrl
  import register_file_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_dump_start,
  input  logic              i_dump_ready,
  output logic              o_dump_valid,
  output logic              o_dump_busy,
  output logic              o_dump_done,
  output logic [NB_REG-1:0] o_dump_index,
  output logic              o_load_en,
  output logic [NB_REG-1:0] o_load_index
);

  dump_state_e       state_q, state_d;
  logic [NB_REG-1:0] index_q, index_d;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= DumpIdle;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    o_load_en    = 1'b0;
    o_load_index = index_q + NB_REG'(1);

    unique case (state_q)
      DumpIdle: begin
        if (i_dump_start) begin
          state_d      = DumpSend;
          index_d      = '0;
          o_load_en    = 1'b1;
          o_load_index = '0;
        end
      end
      DumpSend: begin
        // valid is implied in this state, so ready alone completes the handshake
        if (i_dump_ready) begin
          if (is_last_index(index_q)) begin
            state_d = DumpDone;
          end else begin
            index_d   = index_q + NB_REG'(1);
            o_load_en = 1'b1;
          end
        end
      end
      DumpDone: begin
        state_d = DumpIdle;
        index_d = '0;
      end
      default: begin
        state_d = DumpIdle;
        index_d = '0;
      end
    endcase
  end

  assign o_dump_valid = (state_q == DumpSend);
  assign o_dump_done  = (state_q == DumpDone);
  assign o_dump_busy  = (state_q != DumpIdle);
  assign o_dump_index = index_q;

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit MIPS register file: one write port, two bypassed combinational read ports and a
// handshaked dump stream for the debug unit.
module register_file
  import register_file_pkg::*;
(
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_write_enable,
  input  logic [NB_REG-1:0]  i_write_register,
  input  logic [NB_DATA-1:0] i_write_data,
  input  logic [NB_REG-1:0]  i_read_register_a,
  input  logic [NB_REG-1:0]  i_read_register_b,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  output logic               o_dump_valid,
  output logic [NB_REG-1:0]  o_dump_index,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_busy,
  output logic               o_dump_done
);

  logic [NB_DATA-1:0] regs_q [N_REGS];
  logic [NB_DATA-1:0] dump_data_q;
  logic               load_en;
  logic [NB_REG-1:0]  load_index;
  logic               write_hit;

  assign write_hit = i_write_enable && (i_write_register != '0);

  // r0 is never written, so it stays at its reset value of zero
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (write_hit) begin
      regs_q[i_write_register] <= i_write_data;
    end
  end

  always_comb begin
    o_data_a = '0;
    if (i_read_register_a != '0) begin
      if (write_hit && (i_write_register == i_read_register_a)) begin
        o_data_a = i_write_data;
      end else begin
        o_data_a = regs_q[i_read_register_a];
      end
    end
  end

  always_comb begin
    o_data_b = '0;
    if (i_read_register_b != '0) begin
      if (write_hit && (i_write_register == i_read_register_b)) begin
        o_data_b = i_write_data;
      end else begin
        o_data_b = regs_q[i_read_register_b];
      end
    end
  end

  regfile_dump_ctrl u_dump_ctrl (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_dump_start (i_dump_start),
    .i_dump_ready (i_dump_ready),
    .o_dump_valid (o_dump_valid),
    .o_dump_busy  (o_dump_busy),
    .o_dump_done  (o_dump_done),
    .o_dump_index (o_dump_index),
    .o_load_en    (load_en),
    .o_load_index (load_index)
  );

  // Samples storage, not the bypass path: a write on the loading edge is not captured
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dump_data_q <= '0;
    end else if (load_en) begin
      dump_data_q <= regs_q[load_index];
    end
  end

  assign o_dump_data = dump_data_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: direct read/bypass checks plus a scoreboard on the dump.
module tb_register_file;
  import register_file_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               we = 1'b0;
  logic [NB_REG-1:0]  wr = '0;
  logic [NB_DATA-1:0] wd = '0;
  logic [NB_REG-1:0]  ra = '0;
  logic [NB_REG-1:0]  rb = '0;
  logic [NB_DATA-1:0] da, db;
  logic               start = 1'b0;
  logic               ready = 1'b0;
  logic               valid, busy, done;
  logic [NB_REG-1:0]  didx;
  logic [NB_DATA-1:0] ddata;

  always #5 clk = ~clk;

  register_file dut (
    .i_clock           (clk),
    .i_reset_n         (rst_n),
    .i_write_enable    (we),
    .i_write_register  (wr),
    .i_write_data      (wd),
    .i_read_register_a (ra),
    .i_read_register_b (rb),
    .o_data_a          (da),
    .o_data_b          (db),
    .i_dump_start      (start),
    .i_dump_ready      (ready),
    .o_dump_valid      (valid),
    .o_dump_index      (didx),
    .o_dump_data       (ddata),
    .o_dump_busy       (busy),
    .o_dump_done       (done)
  );

  typedef struct packed {
    logic [NB_REG-1:0]  idx;
    logic [NB_DATA-1:0] data;
  } word_t;

  int                 n_tests = 0;
  int                 n_fail = 0;
  logic [NB_DATA-1:0] mdl [N_REGS];
  word_t              exp_q [$];
  word_t              mon_w;
  bit                 mon_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [NB_REG-1:0] a, input logic [NB_DATA-1:0] d);
    we = 1'b1;
    wr = a;
    wd = d;
    tick();
    we = 1'b0;
    if (a != '0) mdl[a] = d;
  endtask

  task automatic push_dump();
    word_t w;
    for (int i = 0; i < N_REGS; i++) begin
      w.idx  = NB_REG'(i);
      w.data = mdl[i];
      exp_q.push_back(w);
    end
  endtask

  // Scoreboard: every accepted dump word must match the next expected entry
  always @(negedge clk) begin
    if (mon_en && valid && ready) begin
      check_eq("dump_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_w = exp_q.pop_front();
        check_eq("dump_index", 32'(didx), 32'(mon_w.idx));
        check_eq("dump_data", ddata, mon_w.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    bit         stall_done;
    bit         done_seen;
    int         phase;
    int         cyc;

    pat = 4'b1001;
    for (int i = 0; i < N_REGS; i++) mdl[i] = '0;

    // Reset state
    #12;
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ddata", ddata, 32'd0);
    check_eq("rst_didx", 32'(didx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // All addresses read zero on both ports
    for (int a = 0; a < N_REGS; a++) begin
      ra = NB_REG'(a);
      rb = NB_REG'(N_REGS - 1 - a);
      @(negedge clk);
      check_eq("rd_zero_a", da, 32'd0);
      check_eq("rd_zero_b", db, 32'd0);
      tick();
    end

    // Same-cycle bypass on r5, then hold from storage
    ra = 5;
    rb = 6;
    we = 1'b1;
    wr = 5;
    wd = 32'hDEADBEEF;
    @(negedge clk);
    check_eq("bypass_a_r5", da, 32'hDEADBEEF);
    check_eq("no_bypass_b_r6", db, 32'd0);
    tick();
    we = 1'b0;
    mdl[5] = 32'hDEADBEEF;
    @(negedge clk);
    check_eq("hold_a_r5", da, 32'hDEADBEEF);
    tick();

    // Writes to r0 are discarded, bypass included
    ra = 0;
    rb = 0;
    we = 1'b1;
    wr = 0;
    wd = 32'h12345678;
    @(negedge clk);
    check_eq("r0_bypass_a", da, 32'd0);
    check_eq("r0_bypass_b", db, 32'd0);
    tick();
    we = 1'b0;
    @(negedge clk);
    check_eq("r0_after_a", da, 32'd0);
    tick();

    // Full dump with ready held high
    for (int n = 1; n < N_REGS; n++) write_reg(NB_REG'(n), 32'(n * 'h11));
    push_dump();
    mon_en = 1'b1;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      check_eq("d1_valid", 32'(valid), 32'(c <= 32));
      check_eq("d1_done", 32'(done), 32'(c == 33));
      check_eq("d1_busy", 32'(busy), 32'(c <= 33));
      tick();
    end
    check_eq("d1_drained", 32'(exp_q.size()), 32'd0);

    // Dump with ready pattern 1-0-0-1, stall on word 3 with writes and stray starts
    push_dump();
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    stall_done = 1'b0;
    done_seen = 1'b0;
    phase = 0;
    cyc = 0;
    while (!done_seen && cyc < 400) begin
      if (!stall_done && valid && didx == 3) begin
        for (int k = 0; k < 3; k++) begin
          ready = 1'b0;
          start = 1'b1;
          ra = 3;
          we = 1'b1;
          wr = 3;
          wd = 32'hA000 + 32'(k);
          @(negedge clk);
          check_eq("stall_w3_data", ddata, 32'h33);
          check_eq("stall_w3_idx", 32'(didx), 32'd3);
          check_eq("stall_bypass_r3", da, 32'hA000 + 32'(k));
          tick();
          mdl[3] = 32'hA000 + 32'(k);
        end
        we = 1'b0;
        start = 1'b0;
        stall_done = 1'b1;
        cyc += 3;
      end else begin
        ready = pat[phase % 4];
        phase++;
        @(negedge clk);
        if (done) done_seen = 1'b1;
        tick();
        cyc++;
      end
    end
    check_eq("d2_done_seen", 32'(done_seen), 32'd1);
    check_eq("d2_stalled", 32'(stall_done), 32'd1);
    check_eq("d2_drained", 32'(exp_q.size()), 32'd0);
    ra = 3;
    @(negedge clk);
    check_eq("r3_after_dump", da, 32'hA002);
    tick();

    // Asynchronous reset in the middle of a dump
    push_dump();
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (didx != 10 && cyc < 64) begin
      tick();
      cyc++;
    end
    check_eq("reach_idx10", 32'(didx), 32'd10);
    mon_en = 1'b0;
    exp_q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N_REGS; i++) mdl[i] = '0;
    ra = 3;
    rb = 31;
    check_eq("mid_rst_valid", 32'(valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    check_eq("mid_rst_ddata", ddata, 32'd0);
    check_eq("mid_rst_didx", 32'(didx), 32'd0);
    #1;
    check_eq("mid_rst_r3", da, 32'd0);
    check_eq("mid_rst_r31", db, 32'd0);
    tick();
    tick();
    @(negedge clk);
    check_eq("rst_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check_eq("post_rst_done", 32'(done), 32'd0);
    tick();

    // Fresh dump after reset starts at index 0 with cleared data
    push_dump();
    mon_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check_eq("d3_first_idx", 32'(didx), 32'd0);
    check_eq("d3_first_valid", 32'(valid), 32'd1);
    done_seen = 1'b0;
    cyc = 0;
    while (!done_seen && cyc < 40) begin
      tick();
      @(negedge clk);
      if (done) done_seen = 1'b1;
      cyc++;
    end
    check_eq("d3_done_seen", 32'(done_seen), 32'd1);
    check_eq("d3_drained", 32'(exp_q.size()), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
